// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide sequencer.
package md_pkg;

  // md_op encodings of the E-stage instruction
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_NONE  = 3'd7;

  // Sequencer FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  // Default busy durations in cycles
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer: owns HI/LO, times the fixed
// operation latency and raises the D-stage stall request.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC  = max_int(MULT_CYCLES, DIV_CYCLES);
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_s_q, hi_s_d, lo_s_q, lo_s_d;
  logic             dz_q, dz_d;

  logic signed [63:0] rs_sx, rt_sx, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        rs_mag, rt_mag, s_den, q_mag, r_mag, q_s, r_s;
  logic [31:0]        u_den, q_u, r_u;
  logic               div_zero;

  // Operand arithmetic: signed divide works on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  always_comb begin
    rs_sx    = {{32{rs_val[31]}}, rs_val};
    rt_sx    = {{32{rt_val[31]}}, rt_val};
    prod_s   = rs_sx * rt_sx;
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    div_zero = (rt_val == 32'd0);
    rs_mag   = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    rt_mag   = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    s_den    = div_zero ? 32'd1 : rt_mag;
    q_mag    = rs_mag / s_den;
    r_mag    = rs_mag % s_den;
    q_s      = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s      = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
    u_den    = div_zero ? 32'd1 : rt_val;
    q_u      = rs_val / u_den;
    r_u      = rs_val % u_den;
  end

  // Next-state logic: accept ops only in IDLE, count down while busy,
  // commit shadow results on the last busy cycle unless divide-by-zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_s_d  = hi_s_q;
    lo_s_d  = lo_s_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              {hi_s_d, lo_s_d} = (md_op == MD_MULT) ? prod_s : prod_u;
              dz_d    = 1'b0;
              state_d = ST_MUL;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
            end
            MD_DIV, MD_DIVU: begin
              lo_s_d  = (md_op == MD_DIV) ? q_s : q_u;
              hi_s_d  = (md_op == MD_DIV) ? r_s : r_u;
              dz_d    = div_zero;
              state_d = ST_DIV;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
            end
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (!dz_q) begin
            hi_d = hi_s_q;
            lo_d = lo_s_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_s_q  <= '0;
      lo_s_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_s_q  <= hi_s_d;
      lo_s_q  <= lo_s_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign stall_md = md_in_d & (start | busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed cases plus random ops against a
// 64-bit integer arithmetic reference model.
module tb_md_sequencer;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_in_d;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .md_in_d(md_in_d),
    .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic; returns the expected busy length.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 0;
    case (op)
      MD_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; lat = MC; end
      MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; lat = MC; end
      MD_DIV: begin
        lat = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      MD_DIVU: begin
        lat = DC;
        if (b != 0) begin
          q = longint'({32'd0, a}) / longint'({32'd0, b});
          r = longint'({32'd0, a}) % longint'({32'd0, b});
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Called just after a rising edge: issue one op, measure busy and stall, check HI/LO.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic md_d, input string tag);
    int lat, n, ns;
    model_op(op, a, b, lat);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; md_in_d = md_d;
    #1;
    check({tag, ".busy_pre"}, 32'(busy), 32'd0);
    ns = stall_md ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    #1;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (stall_md) ns++;
      @(posedge clk); #2;
    end
    check({tag, ".busy_len"}, 32'(n), 32'(lat));
    check({tag, ".stall_len"}, 32'(ns), md_d ? 32'(lat + 1) : 32'd0);
    check({tag, ".stall_after"}, 32'(stall_md), 32'd0);
    check({tag, ".hi"}, hi, m_hi);
    check({tag, ".lo"}, lo, m_lo);
    md_in_d = 1'b0;
  endtask

  initial begin
    logic [2:0] rop;
    logic [31:0] ra, rb;
    int lat;
    reset = 1'b0; start = 1'b0; md_op = MD_NONE;
    rs_val = '0; rt_val = '0; md_in_d = 1'b0;
    #12;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.hi", hi, 32'd0);
    check("reset.lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    issue(MD_MULT,  32'hFFFFFFFF, 32'h00000002, 1'b0, "t1_mult");
    check("t1.hi_const", hi, 32'hFFFFFFFF);
    check("t1.lo_const", lo, 32'hFFFFFFFE);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0, "t2_multu");
    check("t2.hi_const", hi, 32'h00000001);
    issue(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0, "t3_div");
    check("t3.lo_const", lo, 32'hFFFFFFFD);
    check("t3.hi_const", hi, 32'hFFFFFFFF);
    issue(MD_MTHI,  32'h12345678, 32'h0, 1'b0, "t4_mthi");
    issue(MD_MTLO,  32'h12345678, 32'h0, 1'b0, "t4_mtlo");
    issue(MD_DIVU,  32'h00000099, 32'h0, 1'b0, "t4_divu0");
    check("t4.hi_const", hi, 32'h12345678);
    check("t4.lo_const", lo, 32'h12345678);
    issue(MD_DIV,   32'h55555555, 32'h0, 1'b1, "t4_div0");
    issue(MD_MULT,  32'h00001234, 32'hFFFF0001, 1'b1, "t5_stall");
    issue(MD_MTHI,  32'h0000ABCD, 32'h0, 1'b1, "t5_mthi");
    check("t5.hi_const", hi, 32'h0000ABCD);
    issue(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, "ovf_div");
    check("ovf.lo_const", lo, 32'h80000000);
    check("ovf.hi_const", hi, 32'h00000000);
    issue(3'd6,     32'hDEADBEEF, 32'h1, 1'b1, "undef_op");

    // start during busy is ignored
    model_op(MD_MULTU, 32'h00010000, 32'h00010000, lat);
    start = 1'b1; md_op = MD_MULTU; rs_val = 32'h00010000; rt_val = 32'h00010000;
    @(posedge clk); #1;
    md_op = MD_MTLO; rs_val = 32'hDEAD0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
    check("b2b.busy", 32'(busy), 32'd0);
    check("b2b.hi", hi, m_hi);
    check("b2b.lo", lo, m_lo);

    // random ops, issued right in the cycle after busy falls
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 5))
        0: rop = MD_MULT;  1: rop = MD_MULTU;
        2: rop = MD_DIV;   3: rop = MD_DIVU;
        4: rop = MD_MTHI;  default: rop = MD_MTLO;
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      issue(rop, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end

    // asynchronous reset in DIV busy cycle 4
    model_op(MD_DIV, 32'h00000064, 32'h00000007, lat);
    start = 1'b1; md_op = MD_DIV; rs_val = 32'h64; rt_val = 32'h7;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    repeat (3) begin @(posedge clk); #1; end
    check("rst.busy_before", 32'(busy), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("rst.busy_async", 32'(busy), 32'd0);
    check("rst.hi_async", hi, 32'd0);
    check("rst.lo_async", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (DC + 2) @(posedge clk);
    #1;
    check("rst.idle_busy", 32'(busy), 32'd0);
    check("rst.idle_hi", hi, 32'd0);
    check("rst.idle_lo", lo, 32'd0);
    issue(MD_MULT, 32'h00000003, 32'hFFFFFFFD, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
